ufm_avmm_read_responder: RTL and testbench
==========================================

// Module: ufm_avmm_read_responder
// PURPOSE
//  Avalon-MM read-only responder that stands in for the UFM data port.
//  It is the slave end of the pipelined read interface that the shadow-copy DMA masters.
//  Accepts one read burst at a time, with a programmable number of waitrequest stall cycles.
//  Returns each beat of the burst from an internal word array with a fixed readdatavalid latency.
//  Used both as a synthesizable flash model and as the bench responder for DMA regressions.
// PARAMETERS
//  NUM_WORDS     512                 words in the array
//  ADDR_W        $clog2(NUM_WORDS)   address width, in words
//  BURST_W       2                   burstcount width; a legal burst is 1..2**BURST_W-1 beats
//  WAIT_STATES   3                   cycles waitrequest stays high after read is raised in IDLE (0 allowed)
//  READ_LATENCY  5                   cycles from the acceptance edge to the first readdatavalid (>=1)
//  INIT_FILE     ""                  $readmemh image; if "", mem[i] = 32'h5555_0000 | i
// PORTS
//  clk                  in   1        clock
//  reset_n              in   1        asynchronous, active-low reset
//  avs_read_i           in   1        read request
//  avs_address_i        in   ADDR_W   word address of the first beat
//  avs_burstcount_i     in   BURST_W  beats requested
//  avs_waitrequest_o    out  1        command not accepted this cycle
//  avs_readdatavalid_o  out  1        avs_readdata_o holds a valid beat
//  avs_readdata_o       out  32       read data
//  busy_o               out  1        a burst is accepted and not yet complete
//  err_o                out  1        sticky error: zero burstcount, or address >= NUM_WORDS
// BEHAVIOUR
//  Reset (async): state=IDLE, all counters=0, readdata=0, valid=0, busy=0, err=0.
//   waitrequest=1 while reset_n=0.
//  FSM: IDLE -> LATENCY -> BURST -> IDLE.
//  waitrequest_o is combinational: 1 unless (state==IDLE && ws_cnt==WAIT_STATES).
//  IDLE:
//   - ws_cnt increments each cycle read_i=1, saturating at WAIT_STATES.
//   - ws_cnt clears when read_i=0, so a withdrawn request restarts the stall count.
//  Accept: read_i=1 && waitrequest_o=0 at a clk edge.
//   - Latch address and burstcount; clear ws_cnt; busy=1.
//   - Load lat_cnt = READ_LATENCY-1; go to LATENCY.
//  LATENCY: lat_cnt counts down; at 0, go to BURST.
//   The first valid beat is registered READ_LATENCY edges after the acceptance edge.
//  BURST:
//   - One beat per cycle: valid=1, readdata=mem[addr], addr += 1.
//   - Beats are back-to-back with no gaps; beat count = latched burstcount.
//   - On the last beat, go to IDLE; busy drops with that edge.
//  Earliest next acceptance is the cycle after the last beat, and then only if WAIT_STATES=0.
//   Otherwise the stall count restarts.
//  Address arithmetic: addr wraps modulo 2**ADDR_W.
//   If addr >= NUM_WORDS (non-power-of-2 NUM_WORDS only): readdata=32'hDEAD_BEEF, err=1.
//  burstcount==0: treated as one beat, err=1.
//  readdata holds its last value while valid=0.
//   Changes to read/address/burstcount during a burst are ignored (waitrequest is high).
//  Reset mid-burst: valid and busy drop asynchronously; the remaining beats are discarded.
//   After release the block waits in IDLE for a fresh request.
//  err_o clears only on reset.
// TESTING
//  1 Hold reset_n=0 3 cycles with read=1 -> waitrequest=1, valid=0, readdata=0, no acceptance.
//  2 Single read, addr 0x010, burst 1, defaults:
//     waitrequest high 3 cycles and low in the 4th (accept);
//     valid exactly 5 cycles later with data 0x5555_0010; busy then low.
//  3 Burst 3 at addr 0x1FE:
//     3 consecutive valid beats 0x5555_01FE, 0x5555_01FF, 0x5555_0000 (wrap); err=0.
//  4 burstcount=0 at addr 0x002 -> one beat 0x5555_0002; err=1 and sticky.
//  5 Read held high through a burst -> waitrequest high for the whole burst.
//     Second command accepted WAIT_STATES+1 cycles after the last beat.
//     Also withdraw read after 1 stall cycle -> ws_cnt restarts.
//  6 Reset asserted on the 2nd beat of a 3-beat burst -> valid falls without a clock edge.
//     After release, a new read of addr 0x005 returns 0x5555_0005.
//  7 WAIT_STATES=0, READ_LATENCY=1:
//     back-to-back single reads are accepted on consecutive free cycles;
//     each valid follows its acceptance by one cycle.

Source files
------------

// File: rtl/ufm_avmm_read_responder.sv
// ----------------------------------------------------------------------------
// ufm_avmm_read_responder
//
// Avalon-MM read-only responder standing in for the UFM data port. It is the
// slave end of the pipelined burst-read interface driven by the shadow-copy
// DMA. One burst is accepted at a time. Each command is stalled for
// WAIT_STATES cycles. The beats are then returned back-to-back from a
// read-only word image, with the first beat READ_LATENCY edges after the
// acceptance edge.
//
// The word image is the address pattern 32'h5555_0000 | index. Loading an
// external image (INIT_FILE) cannot be expressed without simulation-only
// constructs, so a non-empty INIT_FILE is rejected at elaboration rather than
// silently ignored.
//
// Ports
//   clk                  in   1        clock
//   reset_n              in   1        asynchronous, active-low reset
//   avs_read_i           in   1        read request
//   avs_address_i        in   ADDR_W   word address of the first beat
//   avs_burstcount_i     in   BURST_W  beats requested (0 is treated as 1, flagged)
//   avs_waitrequest_o    out  1        command not accepted this cycle
//   avs_readdatavalid_o  out  1        avs_readdata_o holds a valid beat
//   avs_readdata_o       out  32       read data, held between beats
//   busy_o               out  1        a burst is accepted and not yet complete
//   err_o                out  1        sticky: zero burstcount or out-of-range word
// ----------------------------------------------------------------------------
module ufm_avmm_read_responder #(
    parameter int    NUM_WORDS    = 512,
    parameter int    ADDR_W       = $clog2(NUM_WORDS),
    parameter int    BURST_W      = 2,
    parameter int    WAIT_STATES  = 3,
    parameter int    READ_LATENCY = 5,
    parameter string INIT_FILE    = ""
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               avs_read_i,
    input  logic [ADDR_W-1:0]  avs_address_i,
    input  logic [BURST_W-1:0] avs_burstcount_i,
    output logic               avs_waitrequest_o,
    output logic               avs_readdatavalid_o,
    output logic [31:0]        avs_readdata_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int WS_W  = (WAIT_STATES > 0)  ? $clog2(WAIT_STATES + 1) : 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY)    : 1;

    localparam logic [WS_W-1:0]   WS_MAX        = WS_W'(WAIT_STATES);
    localparam logic [LAT_W-1:0]  LAT_LOAD      = LAT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_W:0]   NUM_WORDS_EXT = (ADDR_W + 1)'(NUM_WORDS);
    localparam logic [31:0]       OOB_WORD      = 32'hDEAD_BEEF;
    localparam logic [31:0]       IMAGE_BASE    = 32'h5555_0000;

    // Elaboration-time parameter sanity.
    if (INIT_FILE != "") begin : g_init_file_unsupported
        $error("ufm_avmm_read_responder: INIT_FILE images are not supported by this responder");
    end
    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("ufm_avmm_read_responder: READ_LATENCY must be at least 1");
    end
    if (WAIT_STATES < 0) begin : g_bad_wait_states
        $error("ufm_avmm_read_responder: WAIT_STATES must not be negative");
    end
    if (NUM_WORDS > (1 << ADDR_W)) begin : g_bad_addr_w
        $error("ufm_avmm_read_responder: ADDR_W too narrow for NUM_WORDS");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATENCY = 2'd1,
        ST_BURST   = 2'd2
    } state_t;

    state_t             state_r;
    logic [WS_W-1:0]    ws_cnt_r;
    logic [LAT_W-1:0]   lat_cnt_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [BURST_W-1:0] beats_r;

    logic               accept_s;
    logic               beat_fire_s;
    logic               last_beat_s;
    logic               addr_oob_s;
    logic               req_zero_s;
    logic [BURST_W-1:0] req_beats_s;
    logic [31:0]        beat_data_s;

    // Default image word for a given array index.
    function automatic logic [31:0] image_word(input logic [ADDR_W-1:0] idx);
        image_word = IMAGE_BASE | 32'(idx);
    endfunction

    // Command-channel stall: open only in IDLE once the stall count has run out,
    // and held closed while reset is asserted.
    always_comb begin
        if (!reset_n) begin
            avs_waitrequest_o = 1'b1;
        end else if ((state_r == ST_IDLE) && (ws_cnt_r == WS_MAX)) begin
            avs_waitrequest_o = 1'b0;
        end else begin
            avs_waitrequest_o = 1'b1;
        end
    end

    // Acceptance strobe and the effective beat count of the incoming command.
    always_comb begin
        accept_s   = avs_read_i & ~avs_waitrequest_o;
        req_zero_s = (avs_burstcount_i == {BURST_W{1'b0}});
        if (req_zero_s) begin
            req_beats_s = BURST_W'(1);
        end else begin
            req_beats_s = avs_burstcount_i;
        end
    end

    // Beat timing: the first beat fires on the edge where the latency count
    // has reached zero, later beats fire every cycle in BURST.
    always_comb begin
        beat_fire_s = ((state_r == ST_LATENCY) && (lat_cnt_r == {LAT_W{1'b0}})) ||
                      (state_r == ST_BURST);
        last_beat_s = (beats_r == BURST_W'(1));
    end

    // Beat data: words beyond NUM_WORDS (only reachable when NUM_WORDS is not
    // a power of two) return a poison pattern and raise the error flag.
    always_comb begin
        addr_oob_s = ({1'b0, addr_r} >= NUM_WORDS_EXT);
        if (addr_oob_s) begin
            beat_data_s = OOB_WORD;
        end else begin
            beat_data_s = image_word(addr_r);
        end
    end

    // Responder FSM: IDLE stall counting, acceptance, latency countdown and
    // burst beat generation with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r             <= ST_IDLE;
            ws_cnt_r            <= {WS_W{1'b0}};
            lat_cnt_r           <= {LAT_W{1'b0}};
            addr_r              <= {ADDR_W{1'b0}};
            beats_r             <= {BURST_W{1'b0}};
            avs_readdatavalid_o <= 1'b0;
            avs_readdata_o      <= 32'h0000_0000;
            busy_o              <= 1'b0;
            err_o               <= 1'b0;
        end else begin
            avs_readdatavalid_o <= 1'b0;
            if (beat_fire_s) begin
                avs_readdatavalid_o <= 1'b1;
                avs_readdata_o      <= beat_data_s;
                addr_r              <= addr_r + ADDR_W'(1);
                beats_r             <= beats_r - BURST_W'(1);
                if (addr_oob_s) begin
                    err_o <= 1'b1;
                end
                if (last_beat_s) begin
                    state_r <= ST_IDLE;
                    busy_o  <= 1'b0;
                end else begin
                    state_r <= ST_BURST;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            addr_r    <= avs_address_i;
                            beats_r   <= req_beats_s;
                            ws_cnt_r  <= {WS_W{1'b0}};
                            lat_cnt_r <= LAT_LOAD;
                            busy_o    <= 1'b1;
                            state_r   <= ST_LATENCY;
                            if (req_zero_s) begin
                                err_o <= 1'b1;
                            end
                        end else if (avs_read_i) begin
                            // Saturate so a long-pending request keeps the port open.
                            if (ws_cnt_r != WS_MAX) begin
                                ws_cnt_r <= ws_cnt_r + WS_W'(1);
                            end
                        end else begin
                            // A withdrawn request restarts the stall count.
                            ws_cnt_r <= {WS_W{1'b0}};
                        end
                    end
                    ST_LATENCY: begin
                        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    end
                    default: begin
                        // BURST always fires a beat; the unused encoding recovers to IDLE.
                        state_r <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ufm_avmm_read_responder.sv
// ----------------------------------------------------------------------------
// tb_ufm_avmm_read_responder
//
// Two responders: A with the default timing (3 wait states, latency 5,
// 512 words), and B with zero wait states, latency 1 and a 20-word array so
// that the out-of-range poison path is reachable. Commands come from a
// vector table plus hand sequences. Expected beats (data, arrival cycle,
// busy) are queued at acceptance and compared when readdatavalid appears.
// ----------------------------------------------------------------------------
module tb_ufm_avmm_read_responder;

    localparam int A_WS = 3;
    localparam int A_RL = 5;
    localparam int B_NW = 20;
    localparam int B_RL = 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       rd;
    logic [1:0]       wr;
    logic [1:0]       vl;
    logic [1:0]       by;
    logic [1:0]       er;
    logic [1:0][8:0]  ad;
    logic [1:0][1:0]  bcn;
    logic [1:0][31:0] dt;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          sel;
        int          addr;
        int          bc;
        int          nbeats;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        int          stalls;
        int          err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        logic        busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    ufm_avmm_read_responder #(
        .NUM_WORDS(512), .WAIT_STATES(A_WS), .READ_LATENCY(A_RL)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .avs_read_i(rd[0]), .avs_address_i(ad[0]), .avs_burstcount_i(bcn[0]),
        .avs_waitrequest_o(wr[0]), .avs_readdatavalid_o(vl[0]), .avs_readdata_o(dt[0]),
        .busy_o(by[0]), .err_o(er[0])
    );

    ufm_avmm_read_responder #(
        .NUM_WORDS(B_NW), .WAIT_STATES(0), .READ_LATENCY(B_RL)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .avs_read_i(rd[1]), .avs_address_i(ad[1][4:0]), .avs_burstcount_i(bcn[1]),
        .avs_waitrequest_o(wr[1]), .avs_readdatavalid_o(vl[1]), .avs_readdata_o(dt[1]),
        .busy_o(by[1]), .err_o(er[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every readdatavalid beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            exp_t e;
            bit   have;
            have = 1'b0;
            if (vl[s]) begin
                if (s == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    have = 1'b1;
                end else if (s == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    chk("unexpected_beat", {31'd0, vl[s]}, 32'd0);
                end else begin
                    chk("beat_data",  dt[s], e.data);
                    chk("beat_cycle", cyc, e.cyc);
                    chk("beat_busy",  {31'd0, by[s]}, {31'd0, e.busy});
                end
            end
        end
    end

    // Drive a command, count stall cycles, queue its beats at acceptance.
    task automatic issue(input vec_t v, input bit hold, output int acc, output int stalls);
        int rl;
        rl = (v.sel == 0) ? A_RL : B_RL;
        rd[v.sel]  = 1'b1;
        ad[v.sel]  = v.addr[8:0];
        bcn[v.sel] = v.bc[1:0];
        stalls = 0;
        acc    = 0;
        while (wr[v.sel] && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        if (wr[v.sel]) begin
            chk("accept_timeout", {31'd0, wr[v.sel]}, 32'd0);
            rd[v.sel] = 1'b0;
        end else begin
            acc = cyc;
            for (int i = 0; i < v.nbeats; i++) begin
                exp_t e;
                e.data = (i == 0) ? v.d0 : ((i == 1) ? v.d1 : v.d2);
                e.cyc  = acc + 1 + rl + i;
                e.busy = (i != v.nbeats - 1);
                if (v.sel == 0) q0.push_back(e);
                else            q1.push_back(e);
            end
            @(negedge clk);
            if (!hold) rd[v.sel] = 1'b0;
        end
    endtask

    // Wait (bounded) until both responders are idle and all beats arrived.
    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((q0.size() != 0 || q1.size() != 0 || by != 2'b00) && n < 60);
        chk("drain_done", (n < 60) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [9];
        vec_t v;
        int   acc, acc2, acc3, st, last;

        //         sel addr     bc nb  d0             d1             d2             st err
        vt[0] = '{0, 32'h010, 1, 1, 32'h5555_0010, 32'h0,         32'h0,         3, 0};
        vt[1] = '{0, 32'h1FE, 3, 3, 32'h5555_01FE, 32'h5555_01FF, 32'h5555_0000, 3, 0};
        vt[2] = '{0, 32'h100, 2, 2, 32'h5555_0100, 32'h5555_0101, 32'h0,         3, 0};
        vt[3] = '{0, 32'h002, 0, 1, 32'h5555_0002, 32'h0,         32'h0,         3, 1};
        vt[4] = '{0, 32'h1FF, 1, 1, 32'h5555_01FF, 32'h0,         32'h0,         3, 1};
        vt[5] = '{1, 32'h005, 3, 3, 32'h5555_0005, 32'h5555_0006, 32'h5555_0007, 0, 0};
        vt[6] = '{1, 32'h01F, 2, 2, 32'hDEAD_BEEF, 32'h5555_0000, 32'h0,         0, 1};
        vt[7] = '{1, 32'h013, 2, 2, 32'h5555_0013, 32'hDEAD_BEEF, 32'h0,         0, 1};
        vt[8] = '{1, 32'h013, 1, 1, 32'h5555_0013, 32'h0,         32'h0,         0, 1};

        // Reset held with read asserted: nothing may be accepted.
        reset_n = 1'b0;
        rd      = 2'b11;
        ad      = '0;
        bcn     = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wait_a",  {31'd0, wr[0]}, 32'd1);
            chk("rst_wait_b",  {31'd0, wr[1]}, 32'd1);
            chk("rst_valid_a", {31'd0, vl[0]}, 32'd0);
            chk("rst_data_a",  dt[0], 32'h0000_0000);
            chk("rst_busy_a",  {31'd0, by[0]}, 32'd0);
        end
        rd = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy_a", {31'd0, by[0]}, 32'd0);
        chk("idle_wait_b", {31'd0, wr[1]}, 32'd0);

        // Table of single commands, each run to completion.
        for (int i = 0; i < 9; i++) begin
            issue(vt[i], 1'b0, acc, st);
            chk("stall_cycles", st, vt[i].stalls);
            drain();
            chk("err_flag", {31'd0, er[vt[i].sel]}, vt[i].err);
        end

        // Read held through a burst: stalled throughout, next command waits out
        // the full stall count after the last beat.
        v = '{0, 32'h020, 2, 2, 32'h5555_0020, 32'h5555_0021, 32'h0, 3, 1};
        issue(v, 1'b1, acc, st);
        last = acc + 1 + A_RL + 1;
        while (cyc < last) begin
            chk("wait_in_burst", {31'd0, wr[0]}, 32'd1);
            ad[0]  = 9'($urandom);
            bcn[0] = 2'($urandom);
            @(negedge clk);
        end
        v = '{0, 32'h030, 1, 1, 32'h5555_0030, 32'h0, 32'h0, 3, 1};
        issue(v, 1'b0, acc2, st);
        chk("reaccept_gap",    acc2 - last, A_WS);
        chk("reaccept_stalls", st, A_WS);
        drain();

        // Withdrawn request after one stall cycle restarts the stall count.
        rd[0]  = 1'b1;
        ad[0]  = 9'h050;
        bcn[0] = 2'd1;
        @(negedge clk);
        chk("withdraw_wait", {31'd0, wr[0]}, 32'd1);
        rd[0] = 1'b0;
        @(negedge clk);
        v = '{0, 32'h050, 1, 1, 32'h5555_0050, 32'h0, 32'h0, 3, 1};
        issue(v, 1'b0, acc, st);
        chk("restart_stalls", st, A_WS);
        drain();
        chk("err_still_set", {31'd0, er[0]}, 32'd1);

        // Reset on the second beat of a three-beat burst.
        v = '{0, 32'h040, 3, 3, 32'h5555_0040, 32'h5555_0041, 32'h5555_0042, 3, 1};
        issue(v, 1'b0, acc, st);
        while (cyc < acc + 1 + A_RL + 1) @(negedge clk);
        chk("beat2_valid", {31'd0, vl[0]}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid_drop", {31'd0, vl[0]}, 32'd0);
        chk("async_busy_drop",  {31'd0, by[0]}, 32'd0);
        chk("async_wait_high",  {31'd0, wr[0]}, 32'd1);
        q0.delete();
        q1.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("err_cleared", {31'd0, er[0]}, 32'd0);
        v = '{0, 32'h005, 1, 1, 32'h5555_0005, 32'h0, 32'h0, 3, 0};
        issue(v, 1'b0, acc, st);
        chk("post_reset_stalls", st, A_WS);
        drain();
        chk("post_reset_err", {31'd0, er[0]}, 32'd0);

        // Zero wait states, latency 1: back-to-back singles on free cycles.
        v = '{1, 32'h001, 1, 1, 32'h5555_0001, 32'h0, 32'h0, 0, 0};
        issue(v, 1'b1, acc, st);
        chk("b2b_first_stalls", st, 0);
        v = '{1, 32'h002, 1, 1, 32'h5555_0002, 32'h0, 32'h0, 0, 0};
        issue(v, 1'b1, acc2, st);
        chk("b2b_gap_1",    acc2 - acc, 2);
        chk("b2b_stalls_1", st, 1);
        v = '{1, 32'h014, 1, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0};
        issue(v, 1'b0, acc3, st);
        chk("b2b_gap_2", acc3 - acc2, 2);
        drain();
        chk("b_err_set", {31'd0, er[1]}, 32'd1);

        chk("queues_empty", q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
